// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and constants for the common-data-bus result broadcaster.
// Optional same-cycle FIFO bypass is enabled by defining CDB_BYPASS_EN.
package cdb_broadcaster_pkg;

    localparam int NUM_SRC    = 4;
    localparam int TAG_W      = 3;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [SRC_W-1:0] FU_ADD = SRC_W'(0);
    localparam logic [SRC_W-1:0] FU_MUL = SRC_W'(1);
    localparam logic [SRC_W-1:0] FU_LD  = SRC_W'(2);
    localparam logic [SRC_W-1:0] FU_ST  = SRC_W'(3);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_entry_t;

    // Source index 'offset' positions after 'base', wrapping modulo NUM_SRC.
    function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base,
                                                  input int               offset);
        return SRC_W'((int'(base) + offset) % NUM_SRC);
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-functional-unit result FIFO: power-of-two depth, naturally wrapping
// pointers, separately held count, synchronous flush.
module cdb_src_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  cdb_entry_t             data_i,
    input  logic                   pop_i,
    output cdb_entry_t             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cdb_entry_t    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            // A simultaneous push and pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule

// File: rtl/cdb_broadcaster.sv
// Collects FU results into per-source FIFOs and broadcasts one per cycle on a
// registered CDB using round-robin arbitration. CDB_BYPASS_EN: empty-FIFO bypass.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_value,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [SRC_W-1:0]          cdb_src
);

    cdb_entry_t         in_entry [NUM_SRC];
    cdb_entry_t         head     [NUM_SRC];
    logic [CNT_W-1:0]   count    [NUM_SRC];
    logic [NUM_SRC-1:0] full, empty, accept, cand, push, pop, win_hit;

    logic               grant;
    logic [SRC_W-1:0]   win;
    cdb_entry_t         win_entry;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    cdb_entry_t         cdb_entry_q, cdb_entry_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign in_entry[gi] = '{tag:   src_tag[gi*TAG_W +: TAG_W],
                                value: src_value[gi*DATA_W +: DATA_W]};

        // Ready comes from the registered count only; a pop frees space next cycle.
        assign src_ready[gi] = (count[gi] != CNT_W'(FIFO_DEPTH));
        assign accept[gi]    = src_valid[gi] & src_ready[gi] & ~flush;
        assign win_hit[gi]   = grant && (win == SRC_W'(gi));
        assign pop[gi]       = win_hit[gi] & ~empty[gi];
        assign push[gi]      = accept[gi] & ~(win_hit[gi] & empty[gi]);

`ifdef CDB_BYPASS_EN
        // An empty FIFO lets its incoming result compete directly.
        assign cand[gi] = ~empty[gi] | accept[gi];
`else
        assign cand[gi] = ~empty[gi];
`endif

        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .push_i  (push[gi]),
            .data_i  (in_entry[gi]),
            .pop_i   (pop[gi]),
            .head_o  (head[gi]),
            .full_o  (full[gi]),
            .empty_o (empty[gi]),
            .count_o (count[gi])
        );

        assert property (@(posedge clk) disable iff (rst) full[gi] |-> !push[gi]);
        assert property (@(posedge clk) disable iff (rst) pop[gi] |-> !empty[gi]);
    end

    // First candidate after the last winner; no grant during a flush.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!grant && !flush && cand[rr_index(rr_ptr_q, k)]) begin
                grant = 1'b1;
                win   = rr_index(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        win_entry   = empty[win] ? in_entry[win] : head[win];
        cdb_valid_d = grant;
        cdb_entry_d = grant ? win_entry : '0;
        cdb_src_d   = grant ? win : '0;
        rr_ptr_d    = grant ? win : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
            cdb_src_q   <= '0;
            rr_ptr_q    <= SRC_W'(NUM_SRC - 1);
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_entry_q <= cdb_entry_d;
            cdb_src_q   <= cdb_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_entry_q.tag;
    assign cdb_value = cdb_entry_q.value;
    assign cdb_src   = cdb_src_q;

    assert property (@(posedge clk) disable iff (rst) !cdb_valid_q |-> (cdb_entry_q == '0));

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios plus random
// traffic, checked cycle by cycle against a queue-based model of the broadcaster.
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  localparam int ENT_W = TAG_W + DATA_W;
  localparam int OUT_W = 1 + SRC_W + ENT_W;
`ifdef CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_value;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_value;
  logic [SRC_W-1:0]          cdb_src;

  always #5 clk = ~clk;

  cdb_broadcaster dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_value (src_value),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  int total = 0;
  int bad   = 0;

  // reference model: one queue of pending results per source, last winner
  logic [ENT_W-1:0]   mq [NUM_SRC][$];
  int                 m_ptr;
  logic [OUT_W-1:0]   exp_q [$];
  logic [NUM_SRC-1:0] rdy_q [$];
  logic [NUM_SRC-1:0] last_acc;

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    m_ptr = NUM_SRC - 1;
    exp_q.delete();
    rdy_q.delete();
    last_acc = '0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    src_valid[i] = v;
    src_tag[i*TAG_W +: TAG_W] = t;
    src_value[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_tag   = '0;
    src_value = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    clear_src();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Predict this edge from the current inputs, then advance the DUT one cycle.
  task automatic step();
    logic [NUM_SRC-1:0] acc;
    logic [ENT_W-1:0]   ent;
    logic [OUT_W-1:0]   o;
    logic [NUM_SRC-1:0] r;
    int w;
    acc = '0;
    o = '0;
    w = -1;
    for (int i = 0; i < NUM_SRC; i++)
      acc[i] = src_valid[i] && (mq[i].size() < FIFO_DEPTH) && !flush;
    last_acc = acc;
    if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        int c;
        c = (m_ptr + k) % NUM_SRC;
        if (w < 0 && (mq[c].size() > 0 || (BYPASS && acc[c]))) w = c;
      end
      if (w >= 0) begin
        if (mq[w].size() > 0) begin
          ent = mq[w].pop_front();
        end else begin
          ent = {src_tag[w*TAG_W +: TAG_W], src_value[w*DATA_W +: DATA_W]};
          acc[w] = 1'b0;
        end
        m_ptr = w;
        o = {1'b1, SRC_W'(w), ent};
      end
    end
    for (int i = 0; i < NUM_SRC; i++)
      if (acc[i]) mq[i].push_back({src_tag[i*TAG_W +: TAG_W], src_value[i*DATA_W +: DATA_W]});
    for (int i = 0; i < NUM_SRC; i++) r[i] = (mq[i].size() < FIFO_DEPTH);
    exp_q.push_back(o);
    rdy_q.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    rst = 1'b1;
    flush = 1'b0;
    src_valid = '1;
    src_tag = '1;
    src_value = '1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== '0) begin
      bad++;
      $display("FAIL reset_cdb got=%h exp=0", {cdb_valid, cdb_src, cdb_tag, cdb_value});
    end
    total++;
    if (src_ready !== {NUM_SRC{1'b1}}) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=%b", src_ready, {NUM_SRC{1'b1}});
    end
    do_reset();
    for (int s = 0; s < 2; s++) begin
      step();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL reset_idle_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL reset_idle_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
    end
  endtask

  task automatic test_single();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    int seen, seen_at;
    logic [TAG_W-1:0] got_tag;
    logic [DATA_W-1:0] got_val;
    do_reset();
    seen = 0;
    seen_at = -1;
    got_tag = '0;
    got_val = '0;
    set_src(0, 1'b1, TAG_W'(3), 32'h0000_00AA);
    for (int s = 1; s <= 6; s++) begin
      step();
      if (s == 1) clear_src();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL single_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL single_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
      if (cdb_valid === 1'b1) begin
        seen++;
        seen_at = s;
        got_tag = cdb_tag;
        got_val = cdb_value;
      end
    end
    total++;
    if (seen != 1 || seen_at != (BYPASS ? 1 : 2)) begin
      bad++;
      $display("FAIL single_latency got count=%0d edge=%0d exp count=1 edge=%0d", seen, seen_at, BYPASS ? 1 : 2);
    end
    total++;
    if (got_tag !== TAG_W'(3) || got_val !== 32'h0000_00AA) begin
      bad++;
      $display("FAIL single_payload got tag=%0d val=%h exp tag=3 val=000000aa", got_tag, got_val);
    end
  endtask

  task automatic test_all_four();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    int g_src[$];
    int g_tag[$];
    int g_at[$];
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, TAG_W'(i + 1), $urandom);
    for (int s = 1; s <= 7; s++) begin
      step();
      if (s == 1) clear_src();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL all4_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL all4_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
      if (cdb_valid === 1'b1) begin
        g_src.push_back(int'(cdb_src));
        g_tag.push_back(int'(cdb_tag));
        g_at.push_back(s);
      end
    end
    total++;
    if (g_src.size() != NUM_SRC) begin
      bad++;
      $display("FAIL all4_count got=%0d exp=%0d", g_src.size(), NUM_SRC);
    end else begin
      for (int j = 0; j < NUM_SRC; j++) begin
        total++;
        if (g_src[j] != j || g_tag[j] != j + 1 || g_at[j] != g_at[0] + j) begin
          bad++;
          $display("FAIL all4_order idx=%0d got src=%0d tag=%0d edge=%0d exp src=%0d tag=%0d edge=%0d",
                   j, g_src[j], g_tag[j], g_at[j], j, j + 1, g_at[0] + j);
        end
      end
    end
  endtask

  task automatic test_mul_backpressure();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    int n1;
    int got[$];
    do_reset();
    n1 = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (i != 1) set_src(i, 1'b1, TAG_W'($urandom), $urandom);
    set_src(1, 1'b1, TAG_W'(5), $urandom);
    for (int s = 1; s <= 40; s++) begin
      step();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL mul_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL mul_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
      if (cdb_valid === 1'b1 && cdb_src === SRC_W'(1)) got.push_back(int'(cdb_tag));
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i != 1) begin
          if (s >= 12) set_src(i, 1'b0, '0, '0);
          else if (last_acc[i]) set_src(i, 1'b1, TAG_W'($urandom), $urandom);
        end
      end
      if (last_acc[1]) begin
        n1++;
`ifndef CDB_BYPASS_EN
        if (n1 == 2) begin
          total++;
          if (src_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL mul_full got ready1=%b exp=0", src_ready[1]);
          end
        end
`endif
        if (n1 < 3) set_src(1, 1'b1, TAG_W'(5 + n1), $urandom);
        else set_src(1, 1'b0, '0, '0);
      end
    end
    clear_src();
    total++;
    if (n1 != 3 || got.size() != 3) begin
      bad++;
      $display("FAIL mul_total got accepted=%0d broadcast=%0d exp 3 and 3", n1, got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (got[j] != 5 + j) begin
          bad++;
          $display("FAIL mul_order idx=%0d got tag=%0d exp tag=%0d", j, got[j], 5 + j);
        end
      end
    end
  endtask

  task automatic test_alternate();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    int g[$];
    int n_acc;
    do_reset();
    n_acc = 0;
    set_src(0, 1'b1, TAG_W'($urandom), $urandom);
    set_src(2, 1'b1, TAG_W'($urandom), $urandom);
    for (int s = 1; s <= 16; s++) begin
      step();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL alt_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL alt_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
      if (cdb_valid === 1'b1) g.push_back(int'(cdb_src));
      n_acc += int'(last_acc[0]) + int'(last_acc[2]);
      for (int i = 0; i < NUM_SRC; i += 2) begin
        if (s >= 8) set_src(i, 1'b0, '0, '0);
        else if (last_acc[i]) set_src(i, 1'b1, TAG_W'($urandom), $urandom);
      end
    end
    total++;
    if (g.size() != n_acc || g.size() < 4) begin
      bad++;
      $display("FAIL alt_count got grants=%0d exp=%0d (accepted)", g.size(), n_acc);
    end
    for (int j = 1; j < g.size(); j++) begin
      total++;
      if (g[j] == g[j-1] || (g[j] != 0 && g[j] != 2)) begin
        bad++;
        $display("FAIL alt_order idx=%0d got src=%0d prev=%0d exp the other of 0/2", j, g[j], g[j-1]);
      end
    end
  endtask

  task automatic test_flush();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    int after;
    do_reset();
    after = 0;
    set_src(0, 1'b1, TAG_W'(2), $urandom);
    set_src(1, 1'b1, TAG_W'(5), $urandom);
    for (int s = 1; s <= 6; s++) begin
      if (s == 2) flush = 1'b1;
      step();
      clear_src();
      flush = 1'b0;
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL flush_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL flush_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
      if (s == 2) begin
        total++;
        if (cdb_valid !== 1'b0 || src_ready !== {NUM_SRC{1'b1}}) begin
          bad++;
          $display("FAIL flush_clear got valid=%b ready=%b exp valid=0 ready=%b", cdb_valid, src_ready, {NUM_SRC{1'b1}});
        end
      end
      if (s >= 2 && cdb_valid === 1'b1) after++;
    end
    total++;
    if (after != 0) begin
      bad++;
      $display("FAIL flush_leak got broadcasts=%0d exp=0", after);
    end
  endtask

  task automatic test_async_reset();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    int seen, first_src;
    do_reset();
    seen = 0;
    first_src = -1;
    set_src(2, 1'b1, TAG_W'(6), $urandom);
    for (int s = 1; s <= 4 && seen == 0; s++) begin
      step();
      clear_src();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL areset_pre_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL areset_pre_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
      if (cdb_valid === 1'b1) seen = 1;
    end
    total++;
    if (seen == 0) begin
      bad++;
      $display("FAIL areset_nobcast got no broadcast within 4 cycles exp one");
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_src !== '0) begin
      bad++;
      $display("FAIL areset_drop got valid=%b tag=%0d src=%0d exp 0 0 0", cdb_valid, cdb_tag, cdb_src);
    end
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, TAG_W'($urandom), $urandom);
    for (int s = 1; s <= 7; s++) begin
      step();
      clear_src();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL areset_post_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL areset_post_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
      if (cdb_valid === 1'b1 && first_src < 0) first_src = int'(cdb_src);
    end
    total++;
    if (first_src != 0) begin
      bad++;
      $display("FAIL areset_first got src=%0d exp src=0", first_src);
    end
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] e;
    logic [NUM_SRC-1:0] r;
    do_reset();
    for (int s = 1; s <= 320; s++) begin
      if (s <= 300) begin
        for (int i = 0; i < NUM_SRC; i++)
          set_src(i, $urandom_range(0, 2) != 0, TAG_W'($urandom), $urandom);
        flush = ($urandom_range(0, 19) == 0);
      end else begin
        clear_src();
        flush = 1'b0;
      end
      step();
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== e) begin
        bad++;
        $display("FAIL rand_cdb step=%0d got=%h exp=%h", s, {cdb_valid, cdb_src, cdb_tag, cdb_value}, e);
      end
      total++;
      if (src_ready !== r) begin
        bad++;
        $display("FAIL rand_ready step=%0d got=%b exp=%b", s, src_ready, r);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_mul_backpressure();
    test_alternate();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmitter end of the result-broadcast (common data bus) path: the source of the `tag_result_broadcast` traffic that the reservation stations and RAT receive.
- Collects completed results (RS tag + 32-bit value) from the add, mul, load and store functional units.
- Buffers them in small per-unit FIFOs and arbitrates them round-robin onto one registered CDB, one broadcast per cycle.
- Sits between the functional units and the res_station/RAT snoop logic inside SSOOE.

Parameters:
- NUM_SRC, 4, number of functional-unit sources (0=add, 1=mul, 2=ld, 3=st).
- TAG_W, 3, RS tag width (8 reservation stations).
- DATA_W, 32, result value width.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of all buffered results.
- src_valid  input  NUM_SRC  per-unit result valid.
- src_tag  input  NUM_SRC*TAG_W  per-unit RS tag; source i occupies bits [i*TAG_W +: TAG_W].
- src_value  input  NUM_SRC*DATA_W  per-unit result value; same packing.
- src_ready  output  NUM_SRC  per-unit "can accept" flag.
- cdb_valid  output  1  a broadcast is on the bus this cycle.
- cdb_tag  output  TAG_W  broadcast RS tag.
- cdb_value  output  DATA_W  broadcast value.
- cdb_src  output  $clog2(NUM_SRC)  index of the unit that produced the broadcast.

Behaviour:
- Reset (async) state:
  - all FIFOs empty;
  - src_ready all 1;
  - cdb_valid, cdb_tag, cdb_value and cdb_src all 0;
  - round-robin pointer = NUM_SRC-1, so source 0 has first priority.
- Accept:
  - a transfer occurs on source i when src_valid[i] && src_ready[i] at the clock edge;
  - the {tag, value} pair is pushed into FIFO i;
  - src_valid while not ready is ignored: no push, no error.
- src_ready[i] = (count_i != FIFO_DEPTH), decoded from registered state only. There is no combinational path from pop to ready, so a full FIFO that pops in cycle N reports ready in N+1.
- Arbitration, each cycle:
  - candidates are the non-empty FIFOs;
  - the winner is the first candidate searching from pointer+1 upward, modulo NUM_SRC;
  - the winner's head is popped;
  - the pointer is updated to the winner index only when a grant occurs.
- Output, registered:
  - in the cycle after a grant, cdb_valid=1 and cdb_tag/cdb_value/cdb_src carry the popped entry;
  - with no grant, cdb_valid=0 and tag/value/src are driven 0;
  - every broadcast is a single-cycle pulse; there is no downstream backpressure.
- Latency without bypass: accept at edge N; eligible for arbitration in cycle N+1; broadcast visible in cycle N+2 at minimum.
- Simultaneous push and pop on the same FIFO: both happen and the count is unchanged. Pop uses the old head, so ordering within a source is strict FIFO.
- Wrap-around: FIFO read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is held separately, width $clog2(FIFO_DEPTH)+1.
- Fairness: with all sources continuously non-empty, grants cycle 0,1,2,3,0,… and no source waits more than NUM_SRC-1 grants.
- flush:
  - empties all FIFOs and forces the next-cycle cdb_valid=0;
  - inputs arriving in the same cycle as flush are dropped;
  - the pointer is not changed.
- rst asserted mid-broadcast clears cdb_valid immediately (asynchronous); no partial result is emitted after deassert.
- Tag values are not interpreted; any tag, including 0, is broadcast as given.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined:
  - if source i's FIFO is empty (or becomes empty this cycle) and src_valid[i] && src_ready[i], that input joins arbitration in the same cycle;
  - if it wins, it is broadcast at N+1 without being written to the FIFO;
  - if it loses, it is pushed as normal.
  - Non-empty FIFOs are never bypassed, so per-source ordering is preserved.
- Undefined: the latency described under Behaviour holds exactly.

Decomposition:
- InstructionPKG gains:
  - typedef cdb_entry_t {logic [TAG_W-1:0] tag; logic [DATA_W-1:0] value};
  - constants FU_ADD=0, FU_MUL=1, FU_LD=2, FU_ST=3.
- Sub-module cdb_src_fifo (depth FIFO_DEPTH, push/pop/full/empty/count, same clk and rst), instantiated NUM_SRC times via generate.
- Arbiter and output register live in cdb_broadcaster.

Test Plan:
1. Reset, then a single add result (src 0, tag 3, value 0x0000_00AA) at edge 1 -> cdb_valid=1, tag=3, value=0xAA, src=0 in cycle 3 only (cycle 2 with CDB_BYPASS_EN); cdb_valid=0 otherwise.
2. All four sources present tag=i+1 in the same cycle -> four consecutive broadcasts with src order 0,1,2,3 and tags 1,2,3,4; no gaps.
3. mul (src 1) pushes 3 results back-to-back with no pops possible (other sources saturating) -> src_ready[1]=0 after the 2nd push; the 3rd is held by the source; all three are eventually broadcast in order.
4. Sources 0 and 2 continuously valid for 8 cycles -> grants alternate 0,2,0,2…; counts never exceed FIFO_DEPTH.
5. Two results buffered, flush asserted -> next cycle cdb_valid=0, src_ready all 1; buffered tags are never broadcast.
6. rst asserted asynchronously mid-cycle while cdb_valid=1 -> cdb_valid drops before the next edge; after deassert the first grant goes to source 0.
